// File: rtl/soc_msp430_trace_pkg.sv
// Shared definitions for the MSP430 trace monitor: default magic instruction
// encodings and the record held in the output slot.
package soc_msp430_trace_pkg;

    localparam logic [15:0] DEFAULT_TERM_INSN  = 16'h4343;
    localparam logic [15:0] DEFAULT_PRINT_INSN = 16'h4333;
    localparam int          CORE_IDX_W         = 4;
    localparam int          MAX_CORES          = 16;

    typedef struct packed {
        logic [CORE_IDX_W-1:0] core;
        logic [7:0]            ch;
    } out_rec_t;

endpackage

// File: rtl/soc_msp430_trace_fifo.sv
// Per-core print FIFO: 8-bit entries, extra pointer MSB distinguishes full from
// empty. The head entry is read combinationally so the output slot can load it.
module soc_msp430_trace_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic [7:0]  mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_pop   = pop && !empty;
    // A pop on the same edge frees the slot a push into a full FIFO needs.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/soc_msp430_trace_monitor.sv
// Watches retired-instruction traces from several MSP430 cores, collects their
// print characters into per-core FIFOs and serialises them round-robin.
module soc_msp430_trace_monitor
    import soc_msp430_trace_pkg::*;
#(
    parameter int          NUM_CORES  = 1,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] TERM_INSN  = DEFAULT_TERM_INSN,
    parameter logic [15:0] PRINT_INSN = DEFAULT_PRINT_INSN,
    parameter logic [31:0] TIMEOUT    = 32'd0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CORES-1:0]        trace_valid,
    input  logic [NUM_CORES-1:0][15:0]  trace_insn,
    input  logic [NUM_CORES-1:0][15:0]  trace_r3,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [3:0]                  out_core,
    output logic [7:0]                  out_char,
    output logic [NUM_CORES-1:0]        terminated,
    output logic [NUM_CORES-1:0][15:0]  exit_code,
    output logic [NUM_CORES-1:0]        overflow,
    output logic [31:0]                 cycles,
    output logic                        timeout,
    output logic                        done
);

    logic [NUM_CORES-1:0]       live;
    logic [NUM_CORES-1:0]       push;
    logic [NUM_CORES-1:0]       pop;
    logic [NUM_CORES-1:0]       full;
    logic [NUM_CORES-1:0]       empty;
    logic [MAX_CORES-1:0]       empty_pad;
    logic [7:0]                 head_pad [MAX_CORES];

    logic [NUM_CORES-1:0]       terminated_reg, terminated_next;
    logic [NUM_CORES-1:0][15:0] exit_code_reg, exit_code_next;
    logic [NUM_CORES-1:0]       overflow_reg, overflow_next;
    logic [31:0]                cycles_reg, cycles_next;
    logic                       timeout_reg, done_reg;

    out_rec_t                   slot_reg;
    logic                       out_valid_reg;
    logic [3:0]                 rr_ptr_reg, rr_next;
    logic [3:0]                 grant_idx;
    logic                       grant_found;
    logic                       load_en;
    logic                       take;
    logic                       all_term;

    // Cores beyond NUM_CORES are padded as permanently empty so the arbiter
    // can index a fixed 16-entry view with the 4-bit core number.
    for (genvar gi = 0; gi < MAX_CORES; gi++) begin : g_core
        if (gi < NUM_CORES) begin : g_live
            logic [7:0] head;

            assign live[gi] = trace_valid[gi] && !terminated_reg[gi];
            assign push[gi] = live[gi] && (trace_insn[gi] == PRINT_INSN);
            assign pop[gi]  = take && (grant_idx == 4'(gi));

            soc_msp430_trace_fifo #(
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk       (clk),
                .rst_n     (rst_n),
                .push      (push[gi]),
                .push_data (trace_r3[gi][7:0]),
                .pop       (pop[gi]),
                .pop_data  (head),
                .full      (full[gi]),
                .empty     (empty[gi])
            );

            assign empty_pad[gi] = empty[gi];
            assign head_pad[gi]  = head;
        end else begin : g_pad
            assign empty_pad[gi] = 1'b1;
            assign head_pad[gi]  = 8'h00;
        end
    end

    assign all_term = &terminated_reg;
    assign load_en  = !out_valid_reg || out_ready;
    assign take     = load_en && grant_found;

    // Round-robin search begins at rr_ptr_reg, the core after the last grant.
    always_comb begin
        logic [4:0] sum;
        logic [4:0] inc;
        grant_found = 1'b0;
        grant_idx   = 4'd0;
        sum         = 5'd0;
        for (int k = 0; k < NUM_CORES; k++) begin
            sum = {1'b0, rr_ptr_reg} + 5'(k);
            if (sum >= 5'(NUM_CORES)) sum = sum - 5'(NUM_CORES);
            if (!grant_found && !empty_pad[sum[3:0]]) begin
                grant_found = 1'b1;
                grant_idx   = sum[3:0];
            end
        end
        inc     = {1'b0, grant_idx} + 5'd1;
        rr_next = (inc == 5'(NUM_CORES)) ? 4'd0 : inc[3:0];
    end

    always_comb begin
        terminated_next = terminated_reg;
        exit_code_next  = exit_code_reg;
        overflow_next   = overflow_reg;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (live[i] && (trace_insn[i] == TERM_INSN)) begin
                terminated_next[i] = 1'b1;
                exit_code_next[i]  = trace_r3[i];
            end
            if (push[i] && full[i] && !pop[i]) overflow_next[i] = 1'b1;
        end
        cycles_next = cycles_reg;
        if (!all_term && (cycles_reg != 32'hFFFF_FFFF)) cycles_next = cycles_reg + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            terminated_reg <= '0;
            exit_code_reg  <= '0;
            overflow_reg   <= '0;
            cycles_reg     <= '0;
            timeout_reg    <= 1'b0;
            done_reg       <= 1'b0;
            slot_reg       <= '0;
            out_valid_reg  <= 1'b0;
            rr_ptr_reg     <= '0;
        end else begin
            terminated_reg <= terminated_next;
            exit_code_reg  <= exit_code_next;
            overflow_reg   <= overflow_next;
            cycles_reg     <= cycles_next;
            timeout_reg    <= timeout_reg ||
                              ((TIMEOUT != 32'd0) && (cycles_next == TIMEOUT));
            done_reg       <= done_reg || (all_term && (&empty) && !out_valid_reg);
            if (load_en) begin
                out_valid_reg <= grant_found;
                if (grant_found) begin
                    slot_reg.core <= grant_idx;
                    slot_reg.ch   <= head_pad[grant_idx];
                    rr_ptr_reg    <= rr_next;
                end
            end
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_core   = slot_reg.core;
    assign out_char   = slot_reg.ch;
    assign terminated = terminated_reg;
    assign exit_code  = exit_code_reg;
    assign overflow   = overflow_reg;
    assign cycles     = cycles_reg;
    assign timeout    = timeout_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_soc_msp430_trace_monitor.sv
// Bench for the trace monitor: directed vector table, hand sequences for the
// multi-cycle corners, then randomized traffic against a queue-based model.
module tb_soc_msp430_trace_monitor;

    localparam int          NC    = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] TO    = 32'd100;
    localparam logic [15:0] PR    = 16'h4333;
    localparam logic [15:0] TM    = 16'h4343;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NC-1:0]        trace_valid;
    logic [NC-1:0][15:0]  trace_insn;
    logic [NC-1:0][15:0]  trace_r3;
    logic                 out_valid;
    logic                 out_ready;
    logic [3:0]           out_core;
    logic [7:0]           out_char;
    logic [NC-1:0]        terminated;
    logic [NC-1:0][15:0]  exit_code;
    logic [NC-1:0]        overflow;
    logic [31:0]          cycles;
    logic                 timeout;
    logic                 done;

    always #5 clk = ~clk;

    soc_msp430_trace_monitor #(
        .NUM_CORES  (NC),
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .trace_valid (trace_valid),
        .trace_insn  (trace_insn),
        .trace_r3    (trace_r3),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_core    (out_core),
        .out_char    (out_char),
        .terminated  (terminated),
        .exit_code   (exit_code),
        .overflow    (overflow),
        .cycles      (cycles),
        .timeout     (timeout),
        .done        (done)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: per-core character queues plus an output slot.
    logic [7:0]          mq [NC][$];
    int                  m_rr;
    bit                  m_valid;
    int                  m_core;
    logic [7:0]          m_char;
    logic [NC-1:0]       m_term;
    logic [NC-1:0][15:0] m_exit;
    logic [NC-1:0]       m_ovf;
    logic [31:0]         m_cycles;
    bit                  m_timeout;
    bit                  m_done;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) mq[c].delete();
        m_rr = 0; m_valid = 0; m_core = 0; m_char = 8'h00;
        m_term = '0; m_exit = '0; m_ovf = '0;
        m_cycles = 32'd0; m_timeout = 0; m_done = 0;
    endtask

    task automatic model_step();
        bit all_term_pre  = &m_term;
        bit all_empty_pre = 1;
        bit valid_pre     = m_valid;
        for (int c = 0; c < NC; c++) if (mq[c].size() != 0) all_empty_pre = 0;
        if (!m_valid || out_ready) begin
            int g = -1;
            for (int k = 0; k < NC; k++) begin
                int c = (m_rr + k) % NC;
                if (g < 0 && mq[c].size() > 0) g = c;
            end
            if (g >= 0) begin
                m_char  = mq[g].pop_front();
                m_core  = g;
                m_rr    = (g + 1) % NC;
                m_valid = 1;
            end else begin
                m_valid = 0;
            end
        end
        for (int c = 0; c < NC; c++) begin
            if (trace_valid[c] && !m_term[c]) begin
                if (trace_insn[c] == TM) begin
                    m_term[c] = 1'b1;
                    m_exit[c] = trace_r3[c];
                end else if (trace_insn[c] == PR) begin
                    if (mq[c].size() < DEPTH) mq[c].push_back(trace_r3[c][7:0]);
                    else m_ovf[c] = 1'b1;
                end
            end
        end
        if (!all_term_pre && m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
        if (m_cycles == TO) m_timeout = 1;
        if (all_term_pre && all_empty_pre && !valid_pre) m_done = 1;
    endtask

    task automatic compare_all();
        check("out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid) begin
            check("out_core", 64'(out_core), 64'(m_core));
            check("out_char", 64'(out_char), 64'(m_char));
        end
        check("terminated", 64'(terminated), 64'(m_term));
        check("exit_code", 64'(exit_code), 64'(m_exit));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("cycles", 64'(cycles), 64'(m_cycles));
        check("timeout", 64'(timeout), 64'(m_timeout));
        check("done", 64'(done), 64'(m_done));
    endtask

    // Called at a falling edge; advances one clock and compares against the model.
    task automatic tick();
        if (rst_n && out_valid && out_ready)
            $display("emit core=%0d char=%02h cycles=%0d", out_core, out_char, cycles);
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        @(negedge clk);
        compare_all();
        trace_valid = '0;
    endtask

    task automatic beat(int c, logic [15:0] insn, logic [15:0] r3);
        trace_valid[c] = 1'b1;
        trace_insn[c]  = insn;
        trace_r3[c]    = r3;
    endtask

    // Reset lands between edges so its asynchronous effect is observable.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("async_out_valid", 64'(out_valid), 64'd0);
        check("async_cycles", 64'(cycles), 64'd0);
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic run_until(logic [31:0] target);
        for (int g = 0; g < 1000 && m_cycles != target; g++) tick();
        check("reach_cycles", 64'(cycles), 64'(target));
    endtask

    typedef struct packed {
        logic [3:0]  valid;
        logic [63:0] r3;
        logic        exp_valid;
        logic [3:0]  exp_core;
        logic [7:0]  exp_char;
    } vec_t;

    vec_t vecs [14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{4'b1111, 64'h0033_0032_0031_0030, 1'b0, 4'd0, 8'h00};
        vecs[1]  = '{4'b0000, 64'h0,                   1'b1, 4'd0, 8'h30};
        vecs[2]  = '{4'b0000, 64'h0,                   1'b1, 4'd1, 8'h31};
        vecs[3]  = '{4'b1111, 64'h0043_0042_0041_0040, 1'b1, 4'd2, 8'h32};
        vecs[4]  = '{4'b0000, 64'h0,                   1'b1, 4'd3, 8'h33};
        vecs[5]  = '{4'b0000, 64'h0,                   1'b1, 4'd0, 8'h40};
        vecs[6]  = '{4'b0000, 64'h0,                   1'b1, 4'd1, 8'h41};
        vecs[7]  = '{4'b0000, 64'h0,                   1'b1, 4'd2, 8'h42};
        vecs[8]  = '{4'b0000, 64'h0,                   1'b1, 4'd3, 8'h43};
        vecs[9]  = '{4'b0000, 64'h0,                   1'b0, 4'd0, 8'h00};
        vecs[10] = '{4'b0001, 64'h0000_0000_0000_0041, 1'b0, 4'd0, 8'h00};
        vecs[11] = '{4'b0001, 64'h0000_0000_0000_0042, 1'b1, 4'd0, 8'h41};
        vecs[12] = '{4'b0000, 64'h0,                   1'b1, 4'd0, 8'h42};
        vecs[13] = '{4'b0000, 64'h0,                   1'b0, 4'd0, 8'h00};

        rst_n       = 1'b0;
        trace_valid = '0;
        trace_insn  = '0;
        trace_r3    = '0;
        out_ready   = 1'b1;
        model_reset();
        @(negedge clk);
        tick();
        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_terminated", 64'(terminated), 64'd0);
        check("rst_cycles", 64'(cycles), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;

        // Round-robin bursts followed by the two-character core 0 print.
        for (int i = 0; i < 14; i++) begin
            for (int c = 0; c < NC; c++)
                if (vecs[i].valid[c]) beat(c, PR, vecs[i].r3[c*16 +: 16]);
            tick();
            check("tbl_valid", 64'(out_valid), 64'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check("tbl_core", 64'(out_core), 64'(vecs[i].exp_core));
                check("tbl_char", 64'(out_char), 64'(vecs[i].exp_char));
            end
        end

        // Overflow with a stalled consumer, then an in-order drain.
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            beat(1, PR, 16'h0061 + 16'(k));
            tick();
        end
        check("ovf_flag", 64'(overflow[1]), 64'd1);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_char", 64'(out_char), 64'h61);
            check("hold_core", 64'(out_core), 64'd1);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("drain_char", 64'(out_char), 64'h61 + 64'(k));
            tick();
        end
        check("drain_empty", 64'(out_valid), 64'd0);

        // Staggered terminations, cycle freeze and done after draining.
        do_reset();
        out_ready = 1'b0;
        run_until(50); beat(0, TM, 16'h00AA); tick();
        run_until(60); beat(2, TM, 16'h0022); tick();
        run_until(70); beat(3, TM, 16'h0033); beat(1, PR, 16'h005A); tick();
        check("term_with_print", 64'(terminated), 64'hD);
        run_until(78); beat(1, PR, 16'h005B); tick();
        run_until(80); beat(1, TM, 16'h0003); tick();
        beat(0, TM, 16'h1234); tick();
        tick();
        check("all_term", 64'(terminated), 64'hF);
        check("exit_codes", 64'(exit_code), 64'h0033_0022_0003_00AA);
        check("cycles_frozen", 64'(cycles), 64'd81);
        check("done_waits_drain", 64'(done), 64'd0);
        out_ready = 1'b1;
        for (int g = 0; g < 20 && !m_done; g++) tick();
        check("done_set", 64'(done), 64'd1);
        beat(2, PR, 16'h0077); tick(); tick();
        check("done_sticky", 64'(done), 64'd1);
        check("dead_print_ignored", 64'(out_valid), 64'd0);
        check("cycles_still", 64'(cycles), 64'd81);

        // Timeout without any termination.
        do_reset();
        run_until(99);
        check("timeout_before", 64'(timeout), 64'd0);
        tick();
        check("timeout_cycles", 64'(cycles), 64'd100);
        check("timeout_set", 64'(timeout), 64'd1);
        check("timeout_not_done", 64'(done), 64'd0);
        for (int k = 0; k < 5; k++) tick();
        check("timeout_sticky", 64'(timeout), 64'd1);

        // Reset while characters are queued must discard them.
        do_reset();
        out_ready = 1'b0;
        beat(2, PR, 16'h0078); tick();
        beat(2, PR, 16'h0079); tick();
        beat(2, PR, 16'h007A); tick();
        check("queued_valid", 64'(out_valid), 64'd1);
        check("queued_char", 64'(out_char), 64'h78);
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("no_stale", 64'(out_valid), 64'd0);
        end

        // Randomized traffic checked cycle by cycle against the model.
        for (int ep = 0; ep < 4; ep++) begin
            do_reset();
            for (int n = 0; n < 350; n++) begin
                for (int c = 0; c < NC; c++) begin
                    if ($urandom_range(0, 99) < 35) begin
                        int r = $urandom_range(0, 99);
                        logic [15:0] insn;
                        if (r < 75)      insn = PR;
                        else if (r < 78) insn = TM;
                        else             insn = 16'($urandom);
                        beat(c, insn, 16'($urandom));
                    end
                end
                out_ready = ($urandom_range(0, 99) < ((ep == 0) ? 20 : 60));
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/soc_msp430_trace_monitor.md
SOC_MSP430_TRACE_MONITOR -- requirements
Module: soc_msp430_trace_monitor

Interface
REQ-001 Parameters SHALL be:
  - NUM_CORES, 1, number of traced cores (1..16).
  - FIFO_DEPTH, 4, print FIFO entries per core (power of two, >=2).
  - TERM_INSN, 16'h4343, instruction word that terminates a core.
  - PRINT_INSN, 16'h4333, instruction word that prints r3[7:0].
  - TIMEOUT, 0, cycle limit (0 disables the timeout).
REQ-002 Ports SHALL be:
  - clk  in  1  sole clock, all state on its rising edge.
  - rst_n  in  1  reset, asynchronous and active-low.
  - trace_valid  in  NUM_CORES  one retired instruction per core this cycle.
  - trace_insn  in  NUM_CORES x 16  retired instruction word.
  - trace_r3  in  NUM_CORES x 16  r3 value at retirement.
  - out_valid  out  1  print character available.
  - out_ready  in  1  consumer accepts the character.
  - out_core  out  4  source core index.
  - out_char  out  8  character.
  - terminated  out  NUM_CORES  per-core terminated flag.
  - exit_code  out  NUM_CORES x 16  r3 captured at termination.
  - overflow  out  NUM_CORES  sticky per-core FIFO drop flag.
  - cycles  out  32  cycles since reset, saturating.
  - timeout  out  1  cycle limit reached.
  - done  out  1  all cores terminated and all output drained.

Function
REQ-003 A valid trace with insn==TERM_INSN on a live core SHALL set terminated[i] and load exit_code[i]=trace_r3[i] on the same edge.
REQ-004 After terminated[i] is set, all trace_valid[i] beats SHALL be ignored.
REQ-005 A valid trace with insn==PRINT_INSN on a live core SHALL push trace_r3[i][7:0] into FIFO i.
REQ-006 A push to a full FIFO with no pop on the same edge SHALL be dropped and SHALL set overflow[i]; overflow[i] clears only on reset.
REQ-007 A push and a pop on the same edge to a full FIFO SHALL be accepted without overflow.
REQ-008 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH. Empty when pointers are equal; full when the MSBs differ and the rest match.
REQ-009 The output stage SHALL be a single register slot. When the slot is empty, or out_valid&&out_ready, the arbiter SHALL load the next character on that edge. Load-to-visible latency is 1 cycle, and the slot sustains 1 char/cycle.
REQ-010 The arbiter SHALL be round-robin, starting search at the core after the last granted core; the pointer starts at core 0 after reset.
REQ-011 out_core, out_char and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-012 cycles SHALL increment every edge until &terminated is seen, then freeze; at 32'hFFFFFFFF it saturates.
REQ-013 With TIMEOUT!=0, timeout SHALL assert when cycles==TIMEOUT and remain set. With TIMEOUT==0, timeout stays 0.
REQ-014 done SHALL be registered, equal to &terminated && all FIFOs empty && !out_valid, and sticky once set.
REQ-015 A termination and a print on different cores in the same cycle SHALL both take effect.

Reset
REQ-016 While rst_n=0, the following SHALL be 0: all FIFOs empty, arbiter pointer, out_valid, out_core, out_char, terminated, exit_code, overflow, cycles, timeout, done.
REQ-017 Reset asserted mid-transfer SHALL discard queued characters immediately. No character is emitted after rst_n rises until a new PRINT retires.

Structure
REQ-018 Default TERM_INSN/PRINT_INSN encodings and the output record type (core, char) SHALL live in package soc_msp430_trace_pkg.
REQ-019 The per-core FIFO SHALL be sub-module soc_msp430_trace_fifo (parameter DEPTH, 8-bit data, push/pop/full/empty), instantiated NUM_CORES times.

Verification
REQ-020 Core0 prints r3=16'h0041, then 16'h0042, out_ready=1 -> 'A' then 'B' on consecutive cycles, out_core=0, first char one cycle after the push edge.
REQ-021 NUM_CORES=4, all four cores print in the same cycle, out_ready=1 -> emission order core 0,1,2,3; a second burst continues from core 0 after last grant 3.
REQ-022 FIFO_DEPTH=4, out_ready=0, core1 prints 6 chars -> 4 queued, overflow[1]=1. The first out_char holds stable for 10 cycles, then 4 chars drain in order.
REQ-023 Core0 terminates with r3=16'h00AA at cycle 50, core1 terminates with r3=16'h0003 at cycle 80 -> exit_code={3,AA}, cycles frozen at 80±1, done=1 once output drains.
REQ-024 TIMEOUT=100, no termination -> timeout=1 at cycle 100, done=0.
REQ-025 rst_n pulled low while 3 chars are queued and out_valid=1 -> out_valid=0 asynchronously, and no stale chars appear after release.
